// File: rtl/arith_shift_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arith_shift_seq                                            |
// | Description : Sequential arithmetic shifter, one bit position per clock, |
// |               valid/ready in and out. Define ASHIFT_OVF_EN to enable the |
// |               sticky signed-overflow flag V on left shifts.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module arith_shift_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   B,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             V
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_cnt_max = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_release;
  logic [CW-1:0]    w_cnt_load;

  // r_in_ready is only ever high in IDLE, so it qualifies the accept alone
  assign w_accept   = r_in_ready & in_valid;
  assign w_release  = r_out_valid & out_ready;
  assign w_cnt_load = (32'(B) >= 32'(WIDTH)) ? c_cnt_max : CW'(B);

`ifdef ASHIFT_OVF_EN
  logic r_v;
  assign V = r_v;
`else
  assign V = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ASHIFT_OVF_EN
      r_v         <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_data     <= A;
            r_dir      <= dir;
            r_cnt      <= w_cnt_load;
            r_in_ready <= 1'b0;
            r_state    <= ST_SHIFT;
`ifdef ASHIFT_OVF_EN
            r_v        <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_dir) begin
              r_data <= {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            end else begin
              r_data <= {r_data[WIDTH-2:0], 1'b0};
`ifdef ASHIFT_OVF_EN
              // overflow whenever the bit about to become the sign differs from it
              r_v    <= r_v | (r_data[WIDTH-1] ^ r_data[WIDTH-2]);
`endif
            end
          end else begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign X         = r_data;

endmodule
`default_nettype wire

// File: tb/tb_arith_shift_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_arith_shift_seq                                         |
// | Description : Directed scoreboard bench for arith_shift_seq.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_arith_shift_seq;

  localparam int WIDTH = 4;
  localparam int SHW   = 4;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             dir       = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] A         = '0;
  logic [SHW-1:0]   B         = '0;
  logic             in_ready;
  logic             out_valid;
  logic             V;
  logic [WIDTH-1:0] X;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic             v;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  arith_shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .V         (V)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: wide sign-extended shift; overflow iff the bits shifted through
  // the sign position (plus the final sign) are not all equal.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic d);
    exp_t               e;
    int                 n;
    logic signed [7:0]  s;
    logic [4:0]         top;
    n = (b > 4'd4) ? 4 : int'(b);
    s = {{4{a[3]}}, a};
    e.v = 1'b0;
    if (d) begin
      s   = s >>> n;
      e.x = s[3:0];
    end else begin
      s   = s <<< n;
      e.x = s[3:0];
      top = s[7:3];
`ifdef ASHIFT_OVF_EN
      e.v = !((top == 5'b00000) || (top == 5'b11111));
`else
      e.v = (top == 5'b10101) && (top != 5'b10101);
`endif
    end
    e.lat = n + 1;
    return e;
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic d, input int hold);
    exp_t e;
    int   acc;
    int   k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    A = a; B = b; dir = d; in_valid = 1'b1;
    sb.push_back(model(a, b, d));
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    A = ~a; B = 4'($urandom); dir = ~d;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      check("in_ready_busy", 32'(in_ready), 32'd0);
    end
    check("out_valid_rise", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("latency", 32'(cyc - acc), 32'(e.lat));
      check("X", 32'(X), 32'(e.x));
      check("V", 32'(V), 32'(e.v));
      if (hold > 0) begin
        in_valid = 1'b1;
        repeat (hold) begin
          A = 4'($urandom); B = 4'($urandom);
          @(negedge clk);
          check("hold_X", 32'(X), 32'(e.x));
          check("hold_V", 32'(V), 32'(e.v));
          check("hold_out_valid", 32'(out_valid), 32'd1);
          check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // reset state
    #7;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_X", 32'(X), 32'd0);
    check("rst_V", 32'(V), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("first_clk_in_ready", 32'(in_ready), 32'd1);

    run_op(4'b1011, 4'd1, 1'b0, 0);
    run_op(4'b1101, 4'd2, 1'b1, 0);
    run_op(4'b1000, 4'd9, 1'b1, 0);
    run_op(4'b0011, 4'd9, 1'b0, 0);
    run_op(4'b0101, 4'd0, 1'b0, 0);
    run_op(4'b0101, 4'd0, 1'b1, 0);
    run_op(4'b0110, 4'd15, 1'b0, 5);
    run_op(4'b0100, 4'd4, 1'b1, 0);
    run_op(4'b0011, 4'd2, 1'b0, 0);
    run_op(4'b1100, 4'd3, 1'b0, 0);

    // abort mid-shift
    @(negedge clk);
    A = 4'b0111; B = 4'd3; dir = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_X", 32'(X), 32'd0);
    check("abort_V", 32'(V), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_stale_result", 32'(out_valid), 32'd0);
    end
    run_op(4'b1011, 4'd3, 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
